move_stack: RTL

Records the move sequence produced by the maze solver and hands the finished path to the playback queue. The solver pushes a 2-bit move for each step it takes and pops on backtrack. On `finish` the stack freezes and presents the packed path, its length and a one-cycle `done` pulse. These outputs feed the queue's `stack_`, `size` and `done` inputs directly.

---
 rtl/move_stack_if.sv | 30 +++
 rtl/move_stack.sv | 88 ++++++++
 2 files changed

// File: rtl/move_stack_if.sv
// Solver-to-stack command and status bundle for the move stack.
// The master side drives moves/commands; the slave side returns the frozen path and flags.
interface move_stack_if #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned SW    = 8
);
    logic                 push;
    logic                 pop;
    logic [1:0]           move_in;
    logic                 clear;
    logic                 finish;
    logic [2*DEPTH-1:0]   path_out;
    logic [SW-1:0]        size;
    logic [1:0]           top_move;
    logic                 full;
    logic                 empty;
    logic                 done;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output push, pop, move_in, clear, finish,
        input  path_out, size, top_move, full, empty, done, overflow, underflow
    );

    modport slave (
        input  push, pop, move_in, clear, finish,
        output path_out, size, top_move, full, empty, done, overflow, underflow
    );
endinterface

// File: rtl/move_stack.sv
// Move stack: records solver moves (push/pop/replace), freezes on finish and
// presents the packed path, its length and a one-cycle done pulse to the playback queue.
module move_stack #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned SW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    move_stack_if.slave   bus
);
    localparam int unsigned IW = $clog2(2 * DEPTH);

    typedef enum logic [0:0] {StRecord, StFrozen} state_t;

    state_t               r_state;
    logic [2*DEPTH-1:0]   r_path;
    logic [SW-1:0]        r_size;
    logic                 r_done_pend;
    logic                 r_done;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic [SW-1:0]        w_top_entry;
    logic [IW-1:0]        w_wr_bit;
    logic [IW-1:0]        w_top_bit;

    assign w_full      = (r_size == SW'(DEPTH));
    assign w_empty     = (r_size == '0);
    assign w_top_entry = r_size - SW'(1);
    // Truncation is harmless: the write index is only used when the stack is not full.
    assign w_wr_bit    = IW'({r_size, 1'b0});
    assign w_top_bit   = IW'({w_top_entry, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRecord;
            r_path      <= '0;
            r_size      <= '0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // done trails the freeze by one cycle; clear does not cancel an issued pulse.
            r_done      <= r_done_pend;
            r_done_pend <= 1'b0;
            if (bus.clear) begin
                r_state     <= StRecord;
                r_path      <= '0;
                r_size      <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else if (r_state == StRecord) begin
                if (bus.finish) begin
                    r_state     <= StFrozen;
                    r_done_pend <= 1'b1;
                end else if (bus.push && bus.pop && !w_empty) begin
                    r_path[w_top_bit +: 2] <= bus.move_in;
                end else if (bus.push) begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_path[w_wr_bit +: 2] <= bus.move_in;
                        r_size                <= r_size + SW'(1);
                    end
                end else if (bus.pop) begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_path[w_top_bit +: 2] <= 2'b00;
                        r_size                 <= w_top_entry;
                    end
                end
            end
        end
    end

    assign bus.path_out  = r_path;
    assign bus.size      = r_size;
    assign bus.top_move  = w_empty ? 2'b00 : r_path[w_top_bit +: 2];
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.done      = r_done;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
